// File: rtl/vz_upload.sv
// vz_upload: serves a VZ snapshot (24-byte header + RAM range) to hps_io
// during an ioctl upload. One byte is fetched per ioctl_rd strobe; the Z80 is
// held in WAIT for the whole transfer so the RAM image does not change.
module vz_upload #(
  parameter int NAME_LEN = 17,
  parameter int RAM_LAT  = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [15:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [7:0]  file_type,
  input  logic [7:0]  name_char,
  output logic [4:0]  name_idx,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_data,
  output logic        cpu_wait,
  output logic [16:0] image_len,
  output logic        busy,
  output logic        led
);

  // Header layout: "VZF0", filename (last char forced NUL), type, start lo/hi
  localparam logic [15:0] NAME_LAST = 16'(4 + NAME_LEN - 1);
  localparam logic [15:0] TYPE_OFF  = 16'(4 + NAME_LEN);
  localparam logic [15:0] HDR_LEN   = 16'(NAME_LEN + 7);
  localparam logic [1:0]  WAIT_INIT = 2'(RAM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_HDR, S_RAM_REQ, S_RAM_WAIT, S_PRESENT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] start_q, start_d;
  logic [15:0] end_q, end_d;
  logic [7:0]  type_q, type_d;
  logic [16:0] len_q, len_d;
  logic [15:0] off_q, off_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic        ram_rd_q, ram_rd_d;
  logic        cpu_wait_q, cpu_wait_d;
  logic        busy_q, busy_d;
  logic [4:0]  name_idx_q, name_idx_d;
  logic [1:0]  wait_q, wait_d;

  logic        arm_now;
  logic        accept;
  logic        in_hdr;
  logic        in_ram;
  logic [15:0] eff_start;
  logic [16:0] eff_len;
  logic [7:0]  hdr_byte;

  // Image length in 17 bits; an inverted range means an empty RAM section
  function automatic logic [16:0] calc_len(input logic [15:0] s, input logic [15:0] e);
    if (e < s) return {1'b0, HDR_LEN};
    return {1'b0, e} - {1'b0, s} + {1'b0, HDR_LEN} + 17'd1;
  endfunction

  // Request decode; on the arming cycle the live inputs stand in for the
  // not-yet-latched registers so a read in that same cycle sees new values
  always_comb begin
    arm_now   = (state_q == S_IDLE) && ioctl_upload;
    eff_start = arm_now ? start_addr : start_q;
    eff_len   = arm_now ? calc_len(start_addr, end_addr) : len_q;
    accept    = ioctl_rd && ioctl_upload &&
                ((state_q == S_IDLE) || (state_q == S_ARMED));
    in_hdr    = ioctl_addr < HDR_LEN;
    in_ram    = {1'b0, ioctl_addr} < eff_len;
  end

  // Header byte for the latched offset
  always_comb begin
    hdr_byte = 8'h00;
    if (off_q < 16'd4) begin
      case (off_q[1:0])
        2'd0:    hdr_byte = 8'h56;
        2'd1:    hdr_byte = 8'h5A;
        2'd2:    hdr_byte = 8'h46;
        default: hdr_byte = 8'h30;
      endcase
    end else if (off_q < NAME_LAST) begin
      hdr_byte = name_char;
    end else if (off_q == NAME_LAST) begin
      hdr_byte = 8'h00;
    end else if (off_q == TYPE_OFF) begin
      hdr_byte = type_q;
    end else if (off_q == TYPE_OFF + 16'd1) begin
      hdr_byte = start_q[7:0];
    end else begin
      hdr_byte = start_q[15:8];
    end
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping ioctl_upload wins from any state
  always_comb begin
    state_d = state_q;
    if (!ioctl_upload) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ARMED: begin
          state_d = S_ARMED;
          if (ioctl_rd) begin
            if (in_hdr)      state_d = S_HDR;
            else if (in_ram) state_d = S_RAM_REQ;
            else             state_d = S_PRESENT;
          end
        end
        S_HDR:      state_d = S_ARMED;
        S_RAM_REQ:  state_d = S_RAM_WAIT;
        S_RAM_WAIT: if (wait_q == 2'd0) state_d = S_PRESENT;
        S_PRESENT:  state_d = S_ARMED;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    start_d    = start_q;
    end_d      = end_q;
    type_d     = type_q;
    len_d      = len_q;
    off_d      = off_q;
    din_d      = din_q;
    data_d     = data_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    cpu_wait_d = cpu_wait_q;
    busy_d     = busy_q;
    name_idx_d = name_idx_q;
    wait_d     = wait_q;

    if (!ioctl_upload) begin
      cpu_wait_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      if (arm_now) begin
        start_d    = start_addr;
        end_d      = end_addr;
        type_d     = file_type;
        len_d      = calc_len(start_addr, end_addr);
        cpu_wait_d = 1'b1;
      end
      if (accept) begin
        off_d  = ioctl_addr;
        busy_d = 1'b1;
        if (in_hdr) begin
          if (ioctl_addr >= 16'd4 && ioctl_addr <= NAME_LAST)
            name_idx_d = ioctl_addr[4:0] - 5'd4;
        end else begin
          // Address is formed even past the end; only ram_rd gates the access
          ram_addr_d = eff_start + (ioctl_addr - HDR_LEN);
          if (in_ram) ram_rd_d = 1'b1;
          else        data_d   = 8'h00;
        end
      end
      case (state_q)
        S_HDR: begin
          din_d  = hdr_byte;
          busy_d = 1'b0;
        end
        S_RAM_REQ: wait_d = WAIT_INIT;
        S_RAM_WAIT: begin
          if (wait_q == 2'd0) data_d = ram_data;
          else                wait_d = wait_q - 2'd1;
        end
        S_PRESENT: begin
          din_d  = data_q;
          busy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      start_q    <= 16'h0000;
      end_q      <= 16'h0000;
      type_q     <= 8'h00;
      len_q      <= 17'd0;
      off_q      <= 16'h0000;
      din_q      <= 8'h00;
      data_q     <= 8'h00;
      ram_addr_q <= 16'h0000;
      ram_rd_q   <= 1'b0;
      cpu_wait_q <= 1'b0;
      busy_q     <= 1'b0;
      name_idx_q <= 5'd0;
      wait_q     <= 2'd0;
    end else begin
      start_q    <= start_d;
      end_q      <= end_d;
      type_q     <= type_d;
      len_q      <= len_d;
      off_q      <= off_d;
      din_q      <= din_d;
      data_q     <= data_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      cpu_wait_q <= cpu_wait_d;
      busy_q     <= busy_d;
      name_idx_q <= name_idx_d;
      wait_q     <= wait_d;
    end
  end

  assign ioctl_din = din_q;
  assign name_idx  = name_idx_q;
  assign ram_addr  = ram_addr_q;
  assign ram_rd    = ram_rd_q;
  assign cpu_wait  = cpu_wait_q;
  assign led       = cpu_wait_q;
  assign busy      = busy_q;
  assign image_len = len_q;

  // end_q is kept for visibility of the latched range; its effect lives in len_q
  logic unused_end;
  assign unused_end = ^end_q;

endmodule

// File: tb/tb_vz_upload.sv
// Testbench for vz_upload: random RAM and names, reference model computed
// directly from the VZ image layout.
module tb_vz_upload;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [15:0] ioctl_addr = 16'h0;
  logic [7:0]  ioctl_din;
  logic [15:0] start_addr = 16'h0;
  logic [15:0] end_addr = 16'h0;
  logic [7:0]  file_type = 8'h0;
  logic [7:0]  name_char;
  logic [4:0]  name_idx;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_data = 8'h0;
  logic        cpu_wait;
  logic [16:0] image_len;
  logic        busy;
  logic        led;

  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  name_mem [0:16];
  logic [15:0] m_start, m_end;
  logic [7:0]  m_type;

  always #10 clk_sys = ~clk_sys;

  vz_upload #(.NAME_LEN(17), .RAM_LAT(1)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .start_addr(start_addr), .end_addr(end_addr), .file_type(file_type),
    .name_char(name_char), .name_idx(name_idx), .ram_addr(ram_addr),
    .ram_rd(ram_rd), .ram_data(ram_data), .cpu_wait(cpu_wait),
    .image_len(image_len), .busy(busy), .led(led)
  );

  assign name_char = (name_idx < 5'd17) ? name_mem[name_idx] : 8'hEE;

  always @(posedge clk_sys) if (ram_rd) ram_data <= mem[ram_addr];
  always @(posedge clk_sys) if (ram_rd) pulses++;

  function automatic int model_len();
    if (m_end < m_start) return 24;
    return 24 + int'(m_end) - int'(m_start) + 1;
  endfunction

  function automatic logic [7:0] model_byte(int off);
    logic [7:0] magic [0:3];
    magic[0] = 8'h56; magic[1] = 8'h5A; magic[2] = 8'h46; magic[3] = 8'h30;
    if (off < 4)  return magic[off];
    if (off < 20) return name_mem[off-4];
    if (off == 20) return 8'h00;
    if (off == 21) return m_type;
    if (off == 22) return m_start[7:0];
    if (off == 23) return m_start[15:8];
    if (off < model_len()) return mem[(int'(m_start) + off - 24) & 16'hFFFF];
    return 8'h00;
  endfunction

  function automatic int model_pulses(int off);
    return (off >= 24 && off < model_len()) ? 1 : 0;
  endfunction

  task automatic set_cfg(input logic [15:0] s, input logic [15:0] e, input logic [7:0] t);
    start_addr = s; end_addr = e; file_type = t;
    m_start = s; m_end = e; m_type = t;
  endtask

  task automatic scramble();
    start_addr = 16'($urandom); end_addr = 16'($urandom); file_type = 8'($urandom);
  endtask

  task automatic arm();
    @(negedge clk_sys); ioctl_upload = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic disarm();
    @(negedge clk_sys); ioctl_upload = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic set_name_hello();
    for (int i = 0; i < 17; i++) name_mem[i] = 8'h00;
    name_mem[0] = "H"; name_mem[1] = "E"; name_mem[2] = "L";
    name_mem[3] = "L"; name_mem[4] = "O";
  endtask

  // One read strobe; returns the presented byte, latency and ram_rd pulses
  task automatic do_read(input logic [15:0] off, output logic [7:0] b,
                         output int lat, output int np);
    int p0;
    p0 = pulses;
    @(negedge clk_sys); ioctl_addr = off; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    lat = 0;
    while (busy && lat < 20) begin @(negedge clk_sys); lat++; end
    b = ioctl_din;
    np = pulses - p0;
  endtask

  task automatic read_check(input string tag, input int off);
    logic [7:0] b; int lat, np;
    do_read(16'(off), b, lat, np);
    n_checks++;
    if (b !== model_byte(off) || np != model_pulses(off) || lat > 3) begin
      n_fail++;
      $display("FAIL %s off=%0d got=%02h lat=%0d pulses=%0d want=%02h lat<=3 pulses=%0d",
               tag, off, b, lat, np, model_byte(off), model_pulses(off));
    end else
      $display("read %s off=%0d byte=%02h lat=%0d pulses=%0d", tag, off, b, lat, np);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (ioctl_din !== 8'h00 || ram_addr !== 16'h0 || ram_rd !== 1'b0 || cpu_wait !== 1'b0 ||
        busy !== 1'b0 || led !== 1'b0 || name_idx !== 5'd0 || image_len !== 17'd0) begin
      n_fail++;
      $display("FAIL reset din=%02h ra=%04h rd=%b cw=%b busy=%b led=%b ni=%0d len=%0d want all zero",
               ioctl_din, ram_addr, ram_rd, cpu_wait, busy, led, name_idx, image_len);
    end else $display("reset outputs zero");
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_header();
    set_name_hello();
    set_cfg(16'h7AE9, 16'h7AFF, 8'hF0);
    arm();
    scramble();
    n_checks++;
    if (cpu_wait !== 1'b1 || led !== 1'b1 || image_len !== 17'd47 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL arm cw=%b led=%b len=%0d busy=%b want 1 1 47 0", cpu_wait, led, image_len, busy);
    end else $display("arm cw=1 led=1 len=47");
    for (int off = 0; off < 24; off++) read_check("header", off);
  endtask

  task automatic test_ram_body();
    for (int off = 24; off < 47; off++) read_check("ram", off);
    n_checks++;
    if (ram_rd !== 1'b0) begin
      n_fail++; $display("FAIL ram_rd_idle got=%b want=0", ram_rd);
    end else $display("ram_rd idle after body");
  endtask

  task automatic test_empty();
    disarm();
    set_cfg(16'h8000, 16'h7000, 8'hF1);
    arm();
    scramble();
    n_checks++;
    if (image_len !== 17'd24) begin
      n_fail++; $display("FAIL empty_len got=%0d want=24", image_len);
    end else $display("empty len=24");
    read_check("empty", 0);
    read_check("empty", 24);
    read_check("empty", 1);
    read_check("empty", 65535);
  endtask

  task automatic test_wrap();
    disarm();
    set_cfg(16'hFFFE, 16'hFFFF, 8'hF1);
    arm();
    n_checks++;
    if (image_len !== 17'd26) begin
      n_fail++; $display("FAIL wrap_len got=%0d want=26", image_len);
    end else $display("wrap len=26");
    read_check("wrap", 24);
    n_checks++;
    if (ram_addr !== 16'hFFFE) begin
      n_fail++; $display("FAIL wrap_addr got=%04h want=fffe", ram_addr);
    end else $display("wrap ram_addr=fffe");
    read_check("wrap", 25);
    disarm();
    set_cfg(16'hFFFF, 16'hFFFF, 8'hF1);
    arm();
    read_check("wrap1", 24);
    read_check("wrap1", 25);
    n_checks++;
    if (ram_addr !== 16'h0000 || image_len !== 17'd25) begin
      n_fail++; $display("FAIL wrap1_addr got=%04h len=%0d want=0000 len=25", ram_addr, image_len);
    end else $display("wrap1 ram_addr=0000 len=25");
  endtask

  task automatic test_abort();
    disarm();
    set_cfg(16'h7AE9, 16'h7AFF, 8'hF0);
    arm();
    read_check("abort_pre", 0);
    @(negedge clk_sys); ioctl_addr = 16'd30; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_busy got=%b want=1", busy);
    end else $display("abort fetch in flight");
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (cpu_wait !== 1'b0 || led !== 1'b0 || busy !== 1'b0 || ioctl_din !== 8'h56) begin
      n_fail++;
      $display("FAIL abort cw=%b led=%b busy=%b din=%02h want 0 0 0 56", cpu_wait, led, busy, ioctl_din);
    end else $display("abort released cpu, din held");
    repeat (4) @(negedge clk_sys);
    n_checks++;
    if (ioctl_din !== 8'h56) begin
      n_fail++; $display("FAIL abort_hold din=%02h want=56", ioctl_din);
    end else $display("abort din still 56");
    // Reset during a header fetch
    set_cfg(16'h7AE9, 16'h7AFF, 8'hF0);
    arm();
    read_check("rst_pre", 5);
    @(negedge clk_sys); ioctl_addr = 16'd2; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0; reset = 1'b1; ioctl_upload = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (ioctl_din !== 8'h00 || ram_addr !== 16'h0 || ram_rd !== 1'b0 || cpu_wait !== 1'b0 ||
        busy !== 1'b0 || led !== 1'b0 || name_idx !== 5'd0 || image_len !== 17'd0) begin
      n_fail++;
      $display("FAIL midreset din=%02h ra=%04h rd=%b cw=%b busy=%b led=%b ni=%0d len=%0d want all zero",
               ioctl_din, ram_addr, ram_rd, cpu_wait, busy, led, name_idx, image_len);
    end else $display("midreset outputs zero");
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_abuse();
    logic [7:0] b; int lat, np, p0, guard;
    set_cfg(16'h7AE9, 16'h7AFF, 8'hF0);
    arm();
    read_check("abuse_pre", 0);
    p0 = pulses;
    @(negedge clk_sys); ioctl_addr = 16'd30; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    @(negedge clk_sys); ioctl_addr = 16'd5; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin @(negedge clk_sys); guard++; end
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (ioctl_din !== model_byte(30) || pulses - p0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore din=%02h pulses=%0d busy=%b want=%02h 1 0",
               ioctl_din, pulses - p0, busy, model_byte(30));
    end else $display("busy read ignored din=%02h", ioctl_din);
    disarm();
    do_read(16'd0, b, lat, np);
    n_checks++;
    if (b !== model_byte(30) || np != 0 || lat != 0) begin
      n_fail++; $display("FAIL rd_no_upload din=%02h pulses=%0d lat=%0d want=%02h 0 0", b, np, lat, model_byte(30));
    end else $display("read with upload low ignored");
    // Rising edge and read in the same cycle
    set_cfg(16'h1234, 16'h1300, 8'hF1);
    @(negedge clk_sys); ioctl_upload = 1'b1; ioctl_addr = 16'd22; ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0; scramble();
    guard = 0;
    while (busy && guard < 20) begin @(negedge clk_sys); guard++; end
    n_checks++;
    if (ioctl_din !== 8'h34 || cpu_wait !== 1'b1 || image_len !== 17'(model_len())) begin
      n_fail++;
      $display("FAIL rise_rd din=%02h cw=%b len=%0d want=34 1 %0d", ioctl_din, cpu_wait, image_len, model_len());
    end else $display("rise+rd din=34 len=%0d", image_len);
    read_check("order", 30);
    read_check("order", 5);
    read_check("order", 30);
    read_check("order", 22);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      disarm();
      for (int i = 0; i < 17; i++) name_mem[i] = 8'($urandom_range(33, 126));
      begin
        logic [15:0] s, e;
        s = 16'($urandom);
        e = (r == 1) ? s - 16'($urandom_range(1, 50)) : s + 16'($urandom_range(0, 40));
        set_cfg(s, e, 8'($urandom));
      end
      arm();
      scramble();
      for (int k = 0; k < 30; k++) begin
        int off;
        off = (k % 11 == 10) ? 65535 : int'($urandom_range(0, model_len() + 8));
        read_check("random", off);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    set_name_hello();
    test_reset();
    test_header();
    test_ram_body();
    test_empty();
    test_wrap();
    test_abort();
    test_abuse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vz_upload.md
Name: vz_upload

Overview:
- Read-side counterpart of the VZ image download path: serves a VZ snapshot (24-byte header followed by a RAM range) to the HPS byte by byte during an ioctl upload.
- Sits between hps_io's upload port and a second read port of the Laser310 main RAM.
- Stalls the Z80 while an upload is active so the RAM image stays coherent.

Parameters:
- NAME_LEN, 17, filename field length in header bytes (16 chars + NUL).
- RAM_LAT, 1, RAM read latency in clk_sys cycles (supported values 1..3).

Ports:
- clk_sys  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- ioctl_upload  in  1  high for the whole upload transfer
- ioctl_rd  in  1  one-cycle read strobe from hps_io
- ioctl_addr  in  16  byte offset within the image being read
- ioctl_din  out  8  byte returned to hps_io
- start_addr  in  16  first RAM address to save; sampled at upload start
- end_addr  in  16  last RAM address to save, inclusive; sampled at upload start
- file_type  in  8  VZ type byte (0xF0 BASIC, 0xF1 binary); sampled at upload start
- name_char  in  8  filename character for name_idx (combinational lookup)
- name_idx  out  5  filename character index requested
- ram_addr  out  16  RAM read address
- ram_rd  out  1  RAM read enable, one-cycle pulse
- ram_data  in  8  RAM read data, valid RAM_LAT cycles after ram_rd
- cpu_wait  out  1  hold CPU (WAIT_n driven low externally) while high
- image_len  out  17  total image length = 24 + (end_addr - start_addr + 1)
- busy  out  1  high while a byte fetch is in progress
- led  out  1  upload activity indicator

Behaviour:
- Reset: ioctl_din=0x00, ram_addr=0, ram_rd=0, cpu_wait=0, busy=0, led=0, name_idx=0, image_len=0, latched registers=0, state=IDLE. Reset mid-transfer aborts immediately with the same values.
- ioctl_upload rising edge (IDLE→ARMED):
  - Latch start_addr, end_addr and file_type.
  - Compute image_len in 17 bits. If end_addr < start_addr, the RAM section is empty and image_len=24.
  - Assert cpu_wait and led in the cycle after the edge.
- States: IDLE, ARMED, HDR, RAM_REQ, RAM_WAIT, PRESENT.
- ioctl_rd in ARMED at offset A: busy=1, then:
  - A < 24 → HDR:
    - Bytes 0..3 = 0x56 0x5A 0x46 0x30 ("VZF0").
    - Bytes 4..20: name_idx=A-4, byte = name_char; byte 20 is forced to 0x00.
    - Byte 21 = file_type.
    - Byte 22 = start_addr[7:0]; byte 23 = start_addr[15:8].
    - Header bytes are available one cycle after ioctl_rd.
  - 24 ≤ A < image_len → RAM_REQ: ram_addr = start_addr + (A-24) modulo 2^16; pulse ram_rd for one cycle; RAM_WAIT counts RAM_LAT cycles; then capture ram_data.
  - A ≥ image_len → ioctl_din=0x00, no RAM access.
- PRESENT:
  - ioctl_din is updated and busy drops in the same cycle; return to ARMED.
  - ioctl_din holds its value until the next ioctl_rd.
  - Worst-case latency from ioctl_rd to ioctl_din valid is RAM_LAT+2 cycles.
- hps_io spaces ioctl_rd by at least 8 cycles. An ioctl_rd arriving while busy=1 is ignored.
- ioctl_addr is sampled only on ioctl_rd. Out-of-order and repeated offsets are legal and served correctly; the block has no sequential-address assumption.
- ioctl_upload falling edge, from any state:
  - Abandon any fetch and go to IDLE next cycle.
  - cpu_wait=0 and led=0 in that cycle.
  - ioctl_din keeps its last value.
- ioctl_rd while ioctl_upload=0 is ignored.
- ioctl_upload rising and ioctl_rd in the same cycle: latch the inputs, then serve the read using the newly latched values.

Test Plan:
- Header fetch: start=0x7AE9, end=0x7AFF, type=0xF0, name "HELLO" → offsets 0..23 read 56 5A 46 30 48 45 4C 4C 4F 00…00 F0 E9 7A; image_len=47.
- RAM body, RAM_LAT=1: RAM[0x7AE9..0x7AFF]=addr[7:0]; read offsets 24..46 → 0xE9..0xFF, ram_rd pulses once per read, ioctl_din valid ≤3 cycles after ioctl_rd.
- Past-end and empty range: end=0x7000 < start=0x8000 → image_len=24; offset 24 and offset 0xFFFF return 0x00 with no ram_rd pulse.
- Wrap-around: start=0xFFFE, end=0xFFFF → offsets 24,25 fetch RAM 0xFFFE,0xFFFF; image_len=26. Also verify ram_addr wraps to 0x0000 for start=0xFFFF, end=0xFFFF at offset 25 (treated as past-end → 0x00).
- Abort: drop ioctl_upload during RAM_WAIT → no ioctl_din update, cpu_wait=0 next cycle, state IDLE. Assert reset mid-header → all outputs return to reset values the next cycle.
- Protocol abuse: second ioctl_rd while busy is ignored; ioctl_rd with upload low gives no change. Random-order offsets 30,5,30,22 return the correct bytes each time.
